regfile_rd2_wr1: RTL and testbench
==================================

// Module: regfile_rd2_wr1
// PURPOSE
//  32-entry register file built from the 32-bit enable/reset flip-flop storage.
//  It adds the read side: two registered read ports and one write port.
//  It sits between decode and execute in the CPU datapath.
//  It supplies rs/rt operands one cycle after the request, with a valid flag per port.
// PARAMETERS
//  WIDTH  32  data width of each register
//  DEPTH  32  number of registers; register 0 is hardwired to zero
//  AW     5   address width; must equal clog2(DEPTH)
// PORTS
//  clk     in   1      single clock; all state updates on the rising edge
//  nreset  in   1      asynchronous, active-low reset
//  we      in   1      write enable
//  waddr   in   AW     write address
//  wdata   in   WIDTH  write data
//  re1     in   1      read request, port 1
//  raddr1  in   AW     read address, port 1
//  rdata1  out  WIDTH  registered read data, port 1
//  rvalid1 out  1      rdata1 holds data for the request of the previous cycle
//  re2     in   1      read request, port 2
//  raddr2  in   AW     read address, port 2
//  rdata2  out  WIDTH  registered read data, port 2
//  rvalid2 out  1      rdata2 holds data for the request of the previous cycle
// BEHAVIOUR
//  Reset:
//  - nreset low clears all DEPTH registers, rdata1/2=0 and rvalid1/2=0 at once, with no clock edge.
//  - Reset asserted mid-operation discards any in-flight read. rvalid is 0 while nreset is low.
//  - The first edge after nreset rises behaves as a normal cycle.
//  Write:
//  - At the edge, if we=1 and waddr!=0, then reg[waddr] <= wdata.
//  - A write to address 0 is ignored, so reg[0] always reads 0.
//  Read (latency 1 cycle):
//  - At the edge, if reN=1, then rdataN <= reg[raddrN] and rvalidN <= 1.
//  - At the edge, if reN=0, then rvalidN <= 0 and rdataN holds its previous value.
//  - Back-to-back requests give one result per cycle, with no bubbles.
//  - raddrN=0 always returns 0.
//  - Both ports may read the same address in the same cycle. Both return identical data.
//  Addressing:
//  - Addresses >= DEPTH (only possible when DEPTH < 2^AW): a read returns 0, a write is dropped.
//  Simultaneous write and read of the same address (waddr==raddrN!=0, we=1, reN=1):
//  - This behaviour is set by the macro below.
//  - The register array itself always takes the new value at that edge.
//  Width: no arithmetic is performed. Data passes through unmodified at full WIDTH.
// CONFIGURATION
//  REGFILE_BYPASS_EN
//  - Defined: a same-edge write forwards to the read. rdataN <= wdata.
//    Write-before-read, as a single-cycle datapath needs.
//  - Undefined: rdataN <= the old reg[raddrN] (read-before-write).
//    The new value is visible to a read issued on the next edge.
// TESTING
//  - Reset: hold nreset=0, then release. Read all 32 addresses on both ports.
//    Expect rdata=0 for every address. rvalid=1 one cycle after each request.
//  - Write/read: write 0xDEADBEEF to reg 5, then re1=1, raddr1=5.
//    Next cycle expect rdata1=0xDEADBEEF, rvalid1=1.
//    With re1=0 on the following cycle, rvalid1=0 and rdata1 holds.
//  - Reg 0: we=1, waddr=0, wdata=0xFFFFFFFF, then read addr 0 on both ports.
//    Expect rdata1=rdata2=0.
//  - Collision: reg 7=0x11111111, then on one edge write 0x22222222 to reg 7 and read reg 7.
//    With REGFILE_BYPASS_EN: rdata=0x22222222. Without it: rdata=0x11111111.
//  - Dual port, streaming: port 1 reads addresses 1..31 and port 2 reads 31..1, on consecutive cycles.
//    Expect each value exactly one cycle later, with rvalid held at 1 throughout.
//  - Reset mid-read: re1=1 with reg 3=0xA5A5A5A5. Pulse nreset low between edges.
//    rdata1 and rvalid1 go to 0 immediately. Reg 3 then reads back 0.

Source files
------------

// File: rtl/regfile_rd2_wr1.sv
// 32-entry register file, one write port and two registered read ports (latency 1, reg 0 reads zero).
// Build option REGFILE_BYPASS_EN: a same-edge write to a read address forwards wdata to that read port.
module regfile_rd2_wr1 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid1,
    input  logic             re2,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2,
    output logic             rvalid2
);

    // One extra bit so DEPTH == 2**AW is representable.
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata1_r;
    logic [WIDTH-1:0] rdata2_r;
    logic             rvalid1_r;
    logic             rvalid2_r;
    logic             wr_en_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;

    // Address names a real, writable/readable register (not reg 0, not beyond DEPTH).
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return (addr != {AW{1'b0}}) && ({1'b0, addr} < DEPTH_L);
    endfunction

    // Qualify the write request.
    always_comb begin
        wr_en_s = 1'b0;
        if (we && addr_ok(waddr)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Read-side selection for both ports, including the optional write forwarding.
    always_comb begin
        rd1_s = {WIDTH{1'b0}};
        rd2_s = {WIDTH{1'b0}};
        if (addr_ok(raddr1)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_en_s && (waddr == raddr1)) begin
                rd1_s = wdata;
            end else begin
                rd1_s = mem_r[raddr1];
            end
`else
            rd1_s = mem_r[raddr1];
`endif
        end else begin
            rd1_s = {WIDTH{1'b0}};
        end
        if (addr_ok(raddr2)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_en_s && (waddr == raddr2)) begin
                rd2_s = wdata;
            end else begin
                rd2_s = mem_r[raddr2];
            end
`else
            rd2_s = mem_r[raddr2];
`endif
        end else begin
            rd2_s = {WIDTH{1'b0}};
        end
    end

    // Register storage; reg 0 is never written so it stays zero from reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read result registers; data holds when no request is made.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata1_r  <= {WIDTH{1'b0}};
            rdata2_r  <= {WIDTH{1'b0}};
            rvalid1_r <= 1'b0;
            rvalid2_r <= 1'b0;
        end else begin
            rvalid1_r <= re1;
            rvalid2_r <= re2;
            if (re1) begin
                rdata1_r <= rd1_s;
            end
            if (re2) begin
                rdata2_r <= rd2_s;
            end
        end
    end

    assign rdata1  = rdata1_r;
    assign rdata2  = rdata2_r;
    assign rvalid1 = rvalid1_r;
    assign rvalid2 = rvalid2_r;

endmodule

// File: tb/tb_regfile_rd2_wr1.sv
// Randomized self-checking bench for regfile_rd2_wr1 against an array-based register file model.
module tb_regfile_rd2_wr1;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        nreset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        rvalid1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        rvalid2;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [32];
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic        exp_rv1;
    logic        exp_rv2;

    regfile_rd2_wr1 #(.WIDTH(32), .DEPTH(32), .AW(5)) dut (
        .clk(clk), .nreset(nreset),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .rvalid1(rvalid1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .rvalid2(rvalid2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic w,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (BYPASS && w && (wa == a)) return wd;
        return model_mem[a];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
        exp_rd1 = 32'd0;
        exp_rd2 = 32'd0;
        exp_rv1 = 1'b0;
        exp_rv2 = 1'b0;
    endfunction

    // One clock cycle: drive, predict, wait for the edge, compare, return at the next negedge.
    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
        if (r1) exp_rd1 = model_read(a1, w, wa, wd);
        if (r2) exp_rd2 = model_read(a2, w, wa, wd);
        exp_rv1 = r1;
        exp_rv2 = r2;
        if (w && (wa != 5'd0)) model_mem[wa] = wd;
        @(posedge clk);
        #1;
        check("rdata1", rdata1, exp_rd1);
        check("rvalid1", 32'(rvalid1), 32'(exp_rv1));
        check("rdata2", rdata2, exp_rd2);
        check("rvalid2", 32'(rvalid2), 32'(exp_rv2));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        nreset = 1'b1;
        we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
        model_reset();
        #1 nreset = 1'b0;
        #2;
        check("reset_rdata1", rdata1, 32'd0);
        check("reset_rvalid1", 32'(rvalid1), 32'd0);
        check("reset_rdata2", rdata2, 32'd0);
        check("reset_rvalid2", 32'(rvalid2), 32'd0);
        // Requests while reset is held must not produce valid data.
        re1 = 1'b1; re2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("held_rvalid1", 32'(rvalid1), 32'd0);
        check("held_rvalid2", 32'(rvalid2), 32'd0);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(i));

        // Write then read reg 5, then idle cycle holds the data.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        check("wr_rd_reg5", rdata1, 32'hDEADBEEF);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 1'b0, 5'd0);
        check("hold_reg5", rdata1, 32'hDEADBEEF);

        // Reg 0 ignores writes.
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        check("reg0_p1", rdata1, 32'd0);
        check("reg0_p2", rdata2, 32'd0);

        // Same-edge write/read collision on reg 7.
        step(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 1'b1, 5'd7);
        check("collide_p1", rdata1, BYPASS ? 32'h22222222 : 32'h11111111);
        check("collide_p2", rdata2, BYPASS ? 32'h22222222 : 32'h11111111);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0);
        check("after_collide", rdata1, 32'h22222222);

        // Fill all registers, then stream both ports in opposite directions.
        for (int i = 1; i < 32; i++) step(1'b1, 5'(i), $urandom, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 1; i < 32; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(32 - i));

        // Asynchronous reset pulse between edges while a read is outstanding.
        step(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd3);
        check("pre_reset_reg3", rdata1, 32'hA5A5A5A5);
        re1 = 1'b1; raddr1 = 5'd3;
        #1 nreset = 1'b0;
        #1;
        check("midreset_rdata1", rdata1, 32'd0);
        check("midreset_rvalid1", 32'(rvalid1), 32'd0);
        check("midreset_rdata2", rdata2, 32'd0);
        #1 nreset = 1'b1;
        model_reset();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0);
        check("reg3_cleared", rdata1, 32'd0);

        // Random traffic, narrowed address range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            step(r[0], 5'($urandom_range(0, 7)), $urandom,
                 r[1] | r[2], 5'($urandom_range(0, 7)),
                 r[3] | r[4], 5'($urandom_range(0, 7)));
        end
        for (int n = 0; n < 200; n++) begin
            r = $urandom;
            step(r[0], 5'($urandom_range(0, 31)), $urandom,
                 r[1], 5'($urandom_range(0, 31)),
                 r[2], 5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
